// File: rtl/sample_to_dac_code.sv
// Signed DSP sample to unsigned offset-binary DAC code: shift, bias, clamp.
// Two registered stages with valid/ready on both sides and a saturating clip counter.
module sample_to_dac_code #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned OUT_W      = 10,
    parameter int unsigned DC_OFFSET  = 450,
    parameter int unsigned CODE_MAX   = 1023,
    parameter int unsigned GAIN_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [OUT_W-1:0]  m_code,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sat_hi,
    output logic              m_sat_lo,
    output logic [15:0]       sat_count,
    input  logic              clr_sat
);

    // Two guard bits keep shift + bias free of intermediate overflow.
    localparam int unsigned SumW = DATA_W + 2;
    localparam logic signed [SumW-1:0] OffsetS     = SumW'(DC_OFFSET);
    localparam logic signed [SumW-1:0] CodeMaxS    = SumW'(CODE_MAX);
    localparam logic [OUT_W-1:0]       OffsetCode  = OUT_W'(DC_OFFSET);
    localparam logic [OUT_W-1:0]       CodeMaxCode = OUT_W'(CODE_MAX);

    logic signed [SumW-1:0] sum_q, sum_d;
    logic                   st1_valid_q, st1_valid_d;
    logic                   m_valid_q, m_valid_d;
    logic [OUT_W-1:0]       m_code_q, m_code_d;
    logic                   sat_hi_q, sat_hi_d;
    logic                   sat_lo_q, sat_lo_d;
    logic [15:0]            sat_count_q, sat_count_d;

    logic signed [DATA_W-1:0] shifted;
    logic                     accept;
    logic                     st2_load;
    logic                     clamp_lo;
    logic                     clamp_hi;

    assign shifted  = $signed(s_data) >>> GAIN_SHIFT;
    assign s_ready  = !st1_valid_q || !m_valid_q || m_ready;
    assign accept   = s_valid && s_ready;
    assign st2_load = st1_valid_q && (!m_valid_q || m_ready);
    assign clamp_lo = sum_q[SumW-1];
    assign clamp_hi = !clamp_lo && (sum_q > CodeMaxS);

    always_comb begin
        sum_d       = sum_q;
        st1_valid_d = st1_valid_q;
        if (accept) begin
            sum_d       = $signed({{2{shifted[DATA_W-1]}}, shifted}) + OffsetS;
            st1_valid_d = 1'b1;
        end else if (st2_load) begin
            st1_valid_d = 1'b0;
        end
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_code_d  = m_code_q;
        sat_hi_d  = sat_hi_q;
        sat_lo_d  = sat_lo_q;
        if (st2_load) begin
            m_valid_d = 1'b1;
            sat_hi_d  = clamp_hi;
            sat_lo_d  = clamp_lo;
            if (clamp_lo) begin
                m_code_d = '0;
            end else if (clamp_hi) begin
                m_code_d = CodeMaxCode;
            end else begin
                m_code_d = sum_q[OUT_W-1:0];
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_comb begin
        sat_count_d = sat_count_q;
        if (clr_sat) begin
            sat_count_d = '0;
        end else if (st2_load && (clamp_lo || clamp_hi) && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            st1_valid_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_code_q    <= OffsetCode;
            sat_hi_q    <= 1'b0;
            sat_lo_q    <= 1'b0;
            sat_count_q <= '0;
        end else begin
            sum_q       <= sum_d;
            st1_valid_q <= st1_valid_d;
            m_valid_q   <= m_valid_d;
            m_code_q    <= m_code_d;
            sat_hi_q    <= sat_hi_d;
            sat_lo_q    <= sat_lo_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign m_code    = m_code_q;
    assign m_valid   = m_valid_q;
    assign m_sat_hi  = sat_hi_q;
    assign m_sat_lo  = sat_lo_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_sample_to_dac_code.sv
// Directed bench for sample_to_dac_code: vector tables through a scoreboard queue,
// plus hand sequences for stall, counter saturation/clear, async reset and GAIN_SHIFT=2.
module tb_sample_to_dac_code;

    typedef struct {
        logic [15:0] data;
        logic [9:0]  code;
        logic        hi;
        logic        lo;
    } vec_t;

    typedef struct {
        logic [9:0] code;
        logic       hi;
        logic       lo;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [9:0]  m_code;
    logic        m_valid;
    logic        m_ready;
    logic        m_sat_hi;
    logic        m_sat_lo;
    logic [15:0] sat_count;
    logic        clr_sat;

    logic [15:0] s_data2;
    logic        s_valid2;
    logic        s_ready2;
    logic [9:0]  m_code2;
    logic        m_valid2;
    logic        m_sat_hi2;
    logic        m_sat_lo2;
    logic [15:0] sat_count2;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];
    logic        prev_stall = 1'b0;
    logic [11:0] prev_word  = '0;

    sample_to_dac_code dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_code   (m_code),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_sat_hi (m_sat_hi),
        .m_sat_lo (m_sat_lo),
        .sat_count(sat_count),
        .clr_sat  (clr_sat)
    );

    sample_to_dac_code #(.GAIN_SHIFT(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data2),
        .s_valid  (s_valid2),
        .s_ready  (s_ready2),
        .m_code   (m_code2),
        .m_valid  (m_valid2),
        .m_ready  (1'b1),
        .m_sat_hi (m_sat_hi2),
        .m_sat_lo (m_sat_lo2),
        .sat_count(sat_count2),
        .clr_sat  (1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: samples 1 time unit before each rising edge.
    always @(negedge clk) begin
        #4;
        if (!rst) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got code 0x%0h expected none", m_code);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("m_code", 32'(m_code), 32'(e.code));
                    chk("m_sat_hi", 32'(m_sat_hi), 32'(e.hi));
                    chk("m_sat_lo", 32'(m_sat_lo), 32'(e.lo));
                end
            end
            if (m_valid && !m_ready && prev_stall)
                chk("stall_hold", 32'({m_sat_hi, m_sat_lo, m_code}), 32'(prev_word));
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_sat_hi, m_sat_lo, m_code};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Entered and left at a falling edge; leaves s_valid high for back-to-back use.
    task automatic send(input vec_t v);
        exp_t e;
        logic acc;
        e.code = v.code;
        e.hi   = v.hi;
        e.lo   = v.lo;
        exp_q.push_back(e);
        s_data  = v.data;
        s_valid = 1'b1;
        for (int g = 0; g < 50; g++) begin
            #4;
            acc = s_ready;
            @(negedge clk);
            if (acc) return;
        end
        checks++;
        failures++;
        $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    endtask

    task automatic drain();
        for (int g = 0; g < 40 && exp_q.size() != 0; g++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    vec_t t_lin[4];
    vec_t t_sat[4];
    vec_t t_stream[8];
    vec_t t_clamp[3];
    vec_t t_gain[3];

    initial begin
        t_lin[0] = '{16'sd0,      10'd450,  1'b0, 1'b0};
        t_lin[1] = '{-16'sd450,   10'd0,    1'b0, 1'b0};
        t_lin[2] = '{16'sd573,    10'd1023, 1'b0, 1'b0};
        t_lin[3] = '{16'sd100,    10'd550,  1'b0, 1'b0};
        t_sat[0] = '{-16'sd451,   10'd0,    1'b0, 1'b1};
        t_sat[1] = '{16'sd574,    10'd1023, 1'b1, 1'b0};
        t_sat[2] = '{16'h8000,    10'd0,    1'b0, 1'b1};
        t_sat[3] = '{16'sd32767,  10'd1023, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++)
            t_stream[i] = '{16'(i * 10 - 30), 10'(450 + i * 10 - 30), 1'b0, 1'b0};
        t_clamp[0] = '{-16'sd500,  10'd0,    1'b0, 1'b1};
        t_clamp[1] = '{16'sd600,   10'd1023, 1'b1, 1'b0};
        t_clamp[2] = '{-16'sd1000, 10'd0,    1'b0, 1'b1};
        t_gain[0] = '{-16'sd4,     10'd449,  1'b0, 1'b0};
        t_gain[1] = '{16'sd2047,   10'd961,  1'b0, 1'b0};
        t_gain[2] = '{16'sd2400,   10'd1023, 1'b1, 1'b0};

        rst = 1'b1; s_data = '0; s_valid = 1'b0; m_ready = 1'b1; clr_sat = 1'b0;
        s_data2 = '0; s_valid2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_code", 32'(m_code), 32'd450);
        chk("rst_sat_flags", 32'({m_sat_hi, m_sat_lo}), 32'd0);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Linear range, back-to-back.
        foreach (t_lin[i]) send(t_lin[i]);
        s_valid = 1'b0;
        drain();
        chk("sat_count_linear", 32'(sat_count), 32'd0);

        // Clamp boundaries.
        foreach (t_sat[i]) send(t_sat[i]);
        s_valid = 1'b0;
        drain();
        chk("sat_count_four", 32'(sat_count), 32'd4);

        // Stream with a 3-cycle output stall mid-way.
        fork
            begin
                foreach (t_stream[i]) send(t_stream[i]);
                s_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                m_ready = 1'b0;
                repeat (3) begin
                    #4;
                    chk("stall_s_ready", 32'(s_ready), 32'd0);
                    @(negedge clk);
                end
                m_ready = 1'b1;
            end
        join
        drain();

        // Counter saturation then clear-wins.
        force dut.sat_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.sat_count_q;
        @(negedge clk);
        chk("sat_count_preset", 32'(sat_count), 32'hFFFE);
        foreach (t_clamp[i]) send(t_clamp[i]);
        s_valid = 1'b0;
        drain();
        chk("sat_count_hold", 32'(sat_count), 32'hFFFF);
        send('{16'sd700, 10'd1023, 1'b1, 1'b0});
        s_valid = 1'b0;
        clr_sat = 1'b1;
        @(negedge clk);
        clr_sat = 1'b0;
        #4;
        chk("clr_wins_load", 32'(m_valid), 32'd1);
        chk("clr_wins_count", 32'(sat_count), 32'd0);
        drain();

        // Async reset with both stages full.
        m_ready = 1'b0;
        send('{16'sd10, 10'd460, 1'b0, 1'b0});
        send('{16'sd20, 10'd470, 1'b0, 1'b0});
        s_valid = 1'b0;
        #1;
        chk("full_s_ready", 32'(s_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("async_m_valid", 32'(m_valid), 32'd0);
        chk("async_m_code", 32'(m_code), 32'd450);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        exp_q.push_back('{10'd457, 1'b0, 1'b0});
        s_data = 16'sd7;
        s_valid = 1'b1;
        #4;
        chk("post_rst_accept", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        #4;
        chk("latency_c1", 32'(m_valid), 32'd0);
        @(negedge clk);
        #4;
        chk("latency_c2", 32'(m_valid), 32'd1);
        @(negedge clk);
        drain();

        // GAIN_SHIFT = 2 instance.
        foreach (t_gain[i]) begin
            s_data2 = t_gain[i].data;
            s_valid2 = 1'b1;
            @(negedge clk);
            s_valid2 = 1'b0;
            @(negedge clk);
            #4;
            chk("gain_valid", 32'(m_valid2), 32'd1);
            chk("gain_code", 32'(m_code2), 32'(t_gain[i].code));
            chk("gain_hi", 32'(m_sat_hi2), 32'(t_gain[i].hi));
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
